stopwatch_timer_core: RTL and testbench

//  Parametrised BCD stopwatch/countdown core (min:sec:10ms) with an integrated 10 ms prescaler.

---
 rtl/stopwatch_timer_core.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_stopwatch_timer_core.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timer_core.sv
// BCD min:sec:10ms stopwatch / countdown core
// with 10 ms prescaler, preset load, done flag and lap FIFO.
module stopwatch_timer_core #(
   parameter int CLK_DIV   = 500000,
   parameter int MAX_MIN   = 59,
   parameter int LAP_DEPTH = 4
) (
   input  logic       clk_core,
   input  logic       rst,
   input  logic       en,
   input  logic       clr,
   input  logic       load,
   input  logic       mode,
   input  logic [7:0] preset_min,
   input  logic [7:0] preset_sec,
   input  logic [7:0] preset_ms,
   input  logic       lap,
   input  logic       lap_rd,
   output logic [7:0] min_o,
   output logic [7:0] sec_o,
   output logic [7:0] ms_10_o,
   output logic       tick_o,
   output logic       wrap,
   output logic       done,
   output logic       lap_valid,
   output logic       lap_full,
   output logic       lap_ovf,
   output logic [7:0] lap_min,
   output logic [7:0] lap_sec,
   output logic [7:0] lap_ms
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);
   localparam int AW = $clog2(LAP_DEPTH);
   localparam logic [7:0] MAX_BCD =
      8'((MAX_MIN / 10) * 16 + (MAX_MIN % 10));

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [PW-1:0] presc;
   logic          active;
   logic          tick;

   logic at_max;
   logic at_low;
   logic is_zero;

   logic c0, c1, c2, c3, c4;
   logic b0, b1, b2, b3, b4;
   logic [7:0] up_min, up_sec, up_ms;
   logic [7:0] dn_min, dn_sec, dn_ms;
   logic [7:0] cl_min_raw, cl_min, cl_sec, cl_ms;

   logic [23:0]   mem [LAP_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          push;
   logic          pop;

   // Wrapping digit step with explicit top value.
   function automatic logic [3:0] inc_d(
      input logic [3:0] d,
      input logic [3:0] top
   );
      return (d >= top) ? 4'd0 : d + 4'd1;
   endfunction

   function automatic logic [3:0] dec_d(
      input logic [3:0] d,
      input logic [3:0] top
   );
      return (d == 4'd0) ? top : d - 4'd1;
   endfunction

   function automatic logic [3:0] sat(
      input logic [3:0] d,
      input logic [3:0] top
   );
      return (d > top) ? top : d;
   endfunction

   // Prescaler only runs while enabled and not parked in DONE.
   assign active = en && (state != S_DONE);
   assign tick   = rst && active && (presc == PS_LAST);
   assign tick_o = tick;

   assign at_max  = (min_o == MAX_BCD) && (sec_o == 8'h59)
                 && (ms_10_o == 8'h99);
   assign is_zero = (min_o == 8'h00) && (sec_o == 8'h00)
                 && (ms_10_o == 8'h00);
   assign at_low  = (min_o == 8'h00) && (sec_o == 8'h00)
                 && (ms_10_o[7:4] == 4'd0)
                 && (ms_10_o[3:0] <= 4'd1);

   // Up-count carry chain, one BCD digit at a time.
   always_comb begin
      c0 = (ms_10_o[3:0] == 4'd9);
      c1 = c0 && (ms_10_o[7:4] == 4'd9);
      c2 = c1 && (sec_o[3:0] == 4'd9);
      c3 = c2 && (sec_o[7:4] == 4'd5);
      c4 = c3 && (min_o[3:0] == 4'd9);
      up_ms[3:0]  = inc_d(ms_10_o[3:0], 4'd9);
      up_ms[7:4]  = c0 ? inc_d(ms_10_o[7:4], 4'd9)
                       : ms_10_o[7:4];
      up_sec[3:0] = c1 ? inc_d(sec_o[3:0], 4'd9)
                       : sec_o[3:0];
      up_sec[7:4] = c2 ? inc_d(sec_o[7:4], 4'd5)
                       : sec_o[7:4];
      up_min      = min_o;
      if (at_max) begin
         up_min = 8'h00;
      end else if (c3) begin
         up_min[3:0] = inc_d(min_o[3:0], 4'd9);
         up_min[7:4] = c4 ? min_o[7:4] + 4'd1
                          : min_o[7:4];
      end
   end

   // Down-count borrow chain; never used at 00:00:00.
   always_comb begin
      b0 = (ms_10_o[3:0] == 4'd0);
      b1 = b0 && (ms_10_o[7:4] == 4'd0);
      b2 = b1 && (sec_o[3:0] == 4'd0);
      b3 = b2 && (sec_o[7:4] == 4'd0);
      b4 = b3 && (min_o[3:0] == 4'd0);
      dn_ms[3:0]  = dec_d(ms_10_o[3:0], 4'd9);
      dn_ms[7:4]  = b0 ? dec_d(ms_10_o[7:4], 4'd9)
                       : ms_10_o[7:4];
      dn_sec[3:0] = b1 ? dec_d(sec_o[3:0], 4'd9)
                       : sec_o[3:0];
      dn_sec[7:4] = b2 ? dec_d(sec_o[7:4], 4'd5)
                       : sec_o[7:4];
      dn_min[3:0] = b3 ? dec_d(min_o[3:0], 4'd9)
                       : min_o[3:0];
      dn_min[7:4] = b4 ? min_o[7:4] - 4'd1
                       : min_o[7:4];
   end

   // Preset clamping so loaded digits are always legal BCD.
   always_comb begin
      cl_ms      = {sat(preset_ms[7:4], 4'd9),
                    sat(preset_ms[3:0], 4'd9)};
      cl_sec     = {sat(preset_sec[7:4], 4'd5),
                    sat(preset_sec[3:0], 4'd9)};
      cl_min_raw = {sat(preset_min[7:4], 4'd9),
                    sat(preset_min[3:0], 4'd9)};
      cl_min     = (cl_min_raw > MAX_BCD) ? MAX_BCD
                                          : cl_min_raw;
   end

   // Prescaler phase: held by en=0, zeroed by clr/load.
   always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
         presc <= '0;
      end else if (clr || load) begin
         presc <= '0;
      end else if (active) begin
         presc <= (presc == PS_LAST) ? '0 : presc + PW'(1);
      end
   end

   // Time digits: clr > load > tick.
   always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
         min_o   <= 8'h00;
         sec_o   <= 8'h00;
         ms_10_o <= 8'h00;
      end else if (clr) begin
         min_o   <= 8'h00;
         sec_o   <= 8'h00;
         ms_10_o <= 8'h00;
      end else if (load) begin
         min_o   <= cl_min;
         sec_o   <= cl_sec;
         ms_10_o <= cl_ms;
      end else if (tick) begin
         if (!mode) begin
            min_o   <= up_min;
            sec_o   <= up_sec;
            ms_10_o <= up_ms;
         end else if (!is_zero) begin
            min_o   <= dn_min;
            sec_o   <= dn_sec;
            ms_10_o <= dn_ms;
         end
      end
   end

   // Single-cycle rollover pulse, aligned with 00:00:00.
   always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
         wrap <= 1'b0;
      end else begin
         wrap <= !clr && !load && tick && !mode && at_max;
      end
   end

   // State register.
   always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: DONE is entered by a down tick reaching zero.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_RUN: begin
            if (clr || load) begin
               state_nxt = en ? S_RUN : S_IDLE;
            end else if (tick && mode && at_low) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = en ? S_RUN : S_IDLE;
            end
         end
         S_DONE: begin
            if (clr || load) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State outputs.
   always_comb begin
      done = 1'b0;
      unique case (1'b1)
         (state == S_DONE): done = 1'b1;
         default:           done = 1'b0;
      endcase
   end

   assign lap_valid = (wr_ptr != rd_ptr);
   assign lap_full  = (wr_ptr[AW] != rd_ptr[AW])
                   && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop       = lap_rd && lap_valid;
   assign push      = lap && (!lap_full || pop);

   // FIFO pointers; a full FIFO accepts push+pop together.
   always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   // Sticky overflow on a dropped lap.
   always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
         lap_ovf <= 1'b0;
      end else if (clr) begin
         lap_ovf <= 1'b0;
      end else if (lap && lap_full && !pop) begin
         lap_ovf <= 1'b1;
      end
   end

   // Lap storage captures the pre-tick time.
   always_ff @(posedge clk_core) begin
      if (push && !clr) begin
         mem[wr_ptr[AW-1:0]] <= {min_o, sec_o, ms_10_o};
      end
   end

   assign {lap_min, lap_sec, lap_ms} =
      lap_valid ? mem[rd_ptr[AW-1:0]] : 24'h0;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Bench for stopwatch_timer_core: directed steps
// plus randomized traffic against a centisecond model.
module tb_stopwatch_timer_core;

   localparam int CLK_DIV = 4;
   localparam int MAX_MIN = 59;
   localparam int DEPTH   = 4;
   localparam int MAXT    = MAX_MIN * 6000 + 5999;

   logic       clk_core = 1'b0;
   logic       rst;
   logic       en, clr, load, mode, lap, lap_rd;
   logic [7:0] preset_min, preset_sec, preset_ms;
   logic [7:0] min_o, sec_o, ms_10_o;
   logic       tick_o, wrap, done;
   logic       lap_valid, lap_full, lap_ovf;
   logic [7:0] lap_min, lap_sec, lap_ms;

   int checks = 0;
   int fails  = 0;

   int m_t;
   int m_presc;
   bit m_done;
   bit m_wrap;
   bit m_ovf;
   int m_q[$];

   int times[5];

   stopwatch_timer_core #(
      .CLK_DIV  (CLK_DIV),
      .MAX_MIN  (MAX_MIN),
      .LAP_DEPTH(DEPTH)
   ) dut (
      .clk_core  (clk_core),
      .rst       (rst),
      .en        (en),
      .clr       (clr),
      .load      (load),
      .mode      (mode),
      .preset_min(preset_min),
      .preset_sec(preset_sec),
      .preset_ms (preset_ms),
      .lap       (lap),
      .lap_rd    (lap_rd),
      .min_o     (min_o),
      .sec_o     (sec_o),
      .ms_10_o   (ms_10_o),
      .tick_o    (tick_o),
      .wrap      (wrap),
      .done      (done),
      .lap_valid (lap_valid),
      .lap_full  (lap_full),
      .lap_ovf   (lap_ovf),
      .lap_min   (lap_min),
      .lap_sec   (lap_sec),
      .lap_ms    (lap_ms)
   );

   always #5 clk_core = ~clk_core;

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   function automatic logic [23:0] pack(input int t);
      return {bcd(t / 6000), bcd((t / 100) % 60),
              bcd(t % 100)};
   endfunction

   function automatic int lim(input int d, input int top);
      return (d > top) ? top : d;
   endfunction

   function automatic int clamp_t(
      input logic [7:0] pm,
      input logic [7:0] ps,
      input logic [7:0] pc
   );
      int m, s, c;
      m = lim(int'(pm[7:4]), 9) * 10 + lim(int'(pm[3:0]), 9);
      m = lim(m, MAX_MIN);
      s = lim(int'(ps[7:4]), 5) * 10 + lim(int'(ps[3:0]), 9);
      c = lim(int'(pc[7:4]), 9) * 10 + lim(int'(pc[3:0]), 9);
      return m * 6000 + s * 100 + c;
   endfunction

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_t     = 0;
      m_presc = 0;
      m_done  = 0;
      m_wrap  = 0;
      m_ovf   = 0;
      m_q.delete();
   endtask

   task automatic check_all(input string tag);
      logic        exp_tick;
      logic [23:0] head;
      exp_tick = rst && en && !m_done
              && (m_presc == CLK_DIV - 1);
      head = (m_q.size() > 0) ? pack(m_q[0]) : 24'h0;
      chk({tag, ".time"}, {8'h0, min_o, sec_o, ms_10_o},
          {8'h0, pack(m_t)});
      chk({tag, ".tick"}, 32'(tick_o), 32'(exp_tick));
      chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
      chk({tag, ".done"}, 32'(done), 32'(m_done));
      chk({tag, ".valid"}, 32'(lap_valid),
          32'(m_q.size() > 0));
      chk({tag, ".full"}, 32'(lap_full),
          32'(m_q.size() == DEPTH));
      chk({tag, ".ovf"}, 32'(lap_ovf), 32'(m_ovf));
      chk({tag, ".head"}, {8'h0, lap_min, lap_sec, lap_ms},
          {8'h0, head});
   endtask

   task automatic model_edge();
      bit tk;
      bit pp;
      int cur;
      tk  = en && !m_done && (m_presc == CLK_DIV - 1);
      cur = m_t;
      pp  = lap_rd && (m_q.size() > 0);
      if (clr) begin
         m_q.delete();
         m_ovf = 0;
      end else begin
         if (pp) void'(m_q.pop_front());
         if (lap) begin
            if (m_q.size() < DEPTH) m_q.push_back(cur);
            else m_ovf = 1;
         end
      end
      m_wrap = 0;
      if (clr) begin
         m_t = 0; m_presc = 0; m_done = 0;
      end else if (load) begin
         m_t = clamp_t(preset_min, preset_sec, preset_ms);
         m_presc = 0; m_done = 0;
      end else if (tk) begin
         m_presc = 0;
         if (!mode) begin
            if (m_t == MAXT) begin
               m_t = 0; m_wrap = 1;
            end else begin
               m_t++;
            end
         end else if (m_t <= 1) begin
            m_t = 0; m_done = 1;
         end else begin
            m_t--;
         end
      end else if (en && !m_done) begin
         m_presc++;
      end
   endtask

   task automatic cyc(input string tag);
      #1 check_all(tag);
      @(posedge clk_core);
      model_edge();
      @(negedge clk_core);
   endtask

   task automatic set_preset(input logic [7:0] pm,
                             input logic [7:0] ps,
                             input logic [7:0] pc);
      preset_min = pm;
      preset_sec = ps;
      preset_ms  = pc;
   endtask

   initial begin
      rst = 1'b0;
      en = 0; clr = 0; load = 0; mode = 0;
      lap = 0; lap_rd = 0;
      set_preset(8'h00, 8'h00, 8'h00);
      model_reset();
      @(negedge clk_core);
      @(negedge clk_core);
      #1 check_all("reset");
      @(negedge clk_core);
      rst = 1'b1;

      // 1: free run up for 400 cycles
      en = 1;
      repeat (400) cyc("t1");
      #1;
      chk("t1.min", 32'(min_o), 32'h00);
      chk("t1.sec", 32'(sec_o), 32'h01);
      chk("t1.ms", 32'(ms_10_o), 32'h00);

      // 2: rollover from 59:59:99
      en = 0; load = 1;
      set_preset(8'h59, 8'h59, 8'h99);
      cyc("t2.ld");
      load = 0; en = 1;
      repeat (4) cyc("t2");
      #1;
      chk("t2.time", {8'h0, min_o, sec_o, ms_10_o}, 32'h0);
      chk("t2.wrap", 32'(wrap), 32'd1);
      chk("t2.done", 32'(done), 32'd0);
      cyc("t2.after");
      #1 chk("t2.wrap1", 32'(wrap), 32'd0);

      // 3: countdown to done, then hold
      en = 0; load = 1; mode = 1;
      set_preset(8'h00, 8'h00, 8'h02);
      cyc("t3.ld");
      load = 0; en = 1;
      repeat (4) cyc("t3a");
      #1 chk("t3.ms1", 32'(ms_10_o), 32'h01);
      chk("t3.done0", 32'(done), 32'd0);
      repeat (4) cyc("t3b");
      #1 chk("t3.ms0", 32'(ms_10_o), 32'h00);
      chk("t3.done1", 32'(done), 32'd1);
      for (int i = 0; i < 20; i++) begin
         cyc("t3.hold");
         #1 chk("t3.hold.tick", 32'(tick_o), 32'd0);
         chk("t3.hold.done", 32'(done), 32'd1);
      end
      en = 0; clr = 1;
      cyc("t3.clr");
      clr = 0;
      #1 chk("t3.cleared", 32'(done), 32'd0);

      // 4: five laps into a 4-deep FIFO, then drain
      mode = 0; en = 1;
      for (int i = 0; i < 5; i++) begin
         repeat (6) cyc("t4.run");
         times[i] = m_t;
         lap = 1;
         cyc("t4.push");
         lap = 0;
         #1 chk("t4.full", 32'(lap_full), 32'(i >= 3));
         chk("t4.ovf", 32'(lap_ovf), 32'(i >= 4));
      end
      for (int i = 0; i < 4; i++) begin
         lap_rd = 1;
         #1 chk("t4.pop", {8'h0, lap_min, lap_sec, lap_ms},
                {8'h0, pack(times[i])});
         cyc("t4.pop");
      end
      lap_rd = 0;
      #1 chk("t4.empty", 32'(lap_valid), 32'd0);

      // 5: clamped preset
      en = 0; load = 1;
      set_preset(8'h99, 8'h7A, 8'h00);
      cyc("t5.ld");
      load = 0;
      #1 chk("t5.sec", 32'(sec_o), 32'h59);
      chk("t5.min", 32'(min_o), 32'h59);

      // 6: async reset during tick and lap push
      en = 1;
      lap = 1; cyc("t6.fill");
      repeat (3) cyc("t6.run");
      cyc("t6.fill");
      lap = 0;
      for (int i = 0; i < CLK_DIV; i++) begin
         if (m_presc != CLK_DIV - 1) cyc("t6.align");
      end
      chk("t6.align", 32'(m_presc), 32'(CLK_DIV - 1));
      lap = 1;
      #1 check_all("t6.pre");
      chk("t6.tick", 32'(tick_o), 32'd1);
      #2 rst = 0;
      #1 model_reset();
      check_all("t6.rst");
      chk("t6.empty", 32'(lap_valid), 32'd0);
      chk("t6.tick0", 32'(tick_o), 32'd0);
      lap = 0;
      @(negedge clk_core);
      rst = 1;
      repeat (4) cyc("t6.resume");
      #1 chk("t6.ms", {8'h0, min_o, sec_o, ms_10_o},
             32'h000001);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         en     = ($urandom_range(7, 0) != 0);
         clr    = ($urandom_range(199, 0) == 0);
         load   = ($urandom_range(39, 0) == 0);
         lap    = ($urandom_range(5, 0) == 0);
         lap_rd = ($urandom_range(4, 0) == 0);
         if ($urandom_range(15, 0) == 0) mode = ~mode;
         case ($urandom_range(2, 0))
            0: set_preset(8'($urandom), 8'($urandom),
                          8'($urandom));
            1: set_preset(8'h00, 8'h00,
                          bcd($urandom_range(9, 0)));
            default: set_preset(8'h59, 8'h59,
                                bcd($urandom_range(99, 90)));
         endcase
         cyc("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, fails);
      $finish;
   end

endmodule
